// File: rtl/cache_sa_array.sv
// cache_sa_array: set-associative tag/valid/dirty/data storage
// with true-LRU replacement and a multi-cycle flush sweep.
module cache_sa_array #(
    parameter int ADDR_BITS        = 32,
    parameter int WORD_BITS        = 32,
    parameter int WORD_BYTES_WIDTH = 2,
    parameter int LINE_WORDS_WIDTH = 2,
    parameter int SET_INDEX_WIDTH  = 5,
    parameter int WAYS             = 2,
    localparam int WAY_WIDTH = (WAYS > 1) ? $clog2(WAYS) : 1,
    localparam int TAG_BITS  = ADDR_BITS - SET_INDEX_WIDTH
                             - LINE_WORDS_WIDTH - WORD_BYTES_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [ADDR_BITS-1:0] addr,
    input  logic [WORD_BITS-1:0] din,
    input  logic                 load,
    input  logic                 store,
    input  logic                 edit,
    input  logic                 invalid,
    input  logic                 flush,
    output logic                 hit,
    output logic [WAY_WIDTH-1:0] hit_way,
    output logic [WAY_WIDTH-1:0] victim_way,
    output logic                 valid,
    output logic                 dirty,
    output logic [TAG_BITS-1:0]  tag,
    output logic [WORD_BITS-1:0] dout,
    output logic                 busy,
    output logic                 flush_done
);

    localparam int SETS       = 1 << SET_INDEX_WIDTH;
    localparam int LINE_WORDS = 1 << LINE_WORDS_WIDTH;
    localparam int OFS        = WORD_BYTES_WIDTH + LINE_WORDS_WIDTH;
    localparam int DIDX       = SET_INDEX_WIDTH + LINE_WORDS_WIDTH;

    typedef enum logic {
        IDLE,
        SWEEP
    } state_t;

    state_t                     state;
    state_t                     state_nxt;
    logic [SET_INDEX_WIDTH-1:0] cnt;
    logic [SET_INDEX_WIDTH-1:0] cnt_nxt;
    logic                       flush_done_nxt;

    logic [TAG_BITS-1:0]         a_tag;
    logic [SET_INDEX_WIDTH-1:0]  a_set;
    logic [LINE_WORDS_WIDTH-1:0] a_word;
    logic [DIDX-1:0]             a_didx;
    logic                        unused_byte_ofs;

    assign a_tag  = addr[ADDR_BITS-1 -: TAG_BITS];
    assign a_set  = addr[OFS +: SET_INDEX_WIDTH];
    assign a_word = addr[WORD_BYTES_WIDTH +: LINE_WORDS_WIDTH];
    assign a_didx = {a_set, a_word};
    assign unused_byte_ofs = ^addr[WORD_BYTES_WIDTH-1:0];

    logic                 valid_q [WAYS][SETS];
    logic                 dirty_q [WAYS][SETS];
    logic [WAY_WIDTH-1:0] age_q   [WAYS][SETS];
    logic [TAG_BITS-1:0]  tag_q   [WAYS][SETS];
    logic [WORD_BITS-1:0] data_q  [WAYS][SETS*LINE_WORDS];

    logic [WAYS-1:0]      match;
    logic [WAY_WIDTH-1:0] match_way;
    logic [WAY_WIDTH-1:0] vic_way;
    logic [WAY_WIDTH-1:0] sel;

    always_comb begin
        match     = '0;
        match_way = '0;
        vic_way   = '0;
        for (int i = 0; i < WAYS; i++) begin
            match[i] = valid_q[i][a_set]
                     && (tag_q[i][a_set] == a_tag);
        end
        // Scan downwards so the lowest matching way wins.
        for (int i = WAYS - 1; i >= 0; i--) begin
            if (match[i]) match_way = WAY_WIDTH'(i);
        end
        for (int i = 0; i < WAYS; i++) begin
            if (age_q[i][a_set] == WAY_WIDTH'(WAYS - 1))
                vic_way = WAY_WIDTH'(i);
        end
    end

    assign busy       = (state == SWEEP);
    assign hit        = (|match) && !busy && !flush;
    assign hit_way    = hit ? match_way : '0;
    assign sel        = hit ? match_way : vic_way;
    assign victim_way = vic_way;
    assign valid      = valid_q[vic_way][a_set];
    assign dirty      = dirty_q[vic_way][a_set];
    assign tag        = tag_q[vic_way][a_set];

    logic req_ok;
    logic do_inv;
    logic do_store;
    logic do_edit;
    logic do_load;
    logic touch;
    logic wr_data;

    assign req_ok = !busy && !flush;

    always_comb begin
        do_inv   = 1'b0;
        do_store = 1'b0;
        do_edit  = 1'b0;
        do_load  = 1'b0;
        if (req_ok) begin
            if (invalid)
                do_inv = hit;
            else if (store)
                do_store = 1'b1;
            else if (edit)
                do_edit = hit;
            else if (load)
                do_load = hit;
        end
    end

    assign touch   = do_store || do_edit || do_load;
    assign wr_data = do_store || do_edit;

    logic [WAY_WIDTH-1:0] age_new [WAYS];

    always_comb begin
        for (int i = 0; i < WAYS; i++) begin
            age_new[i] = age_q[i][a_set];
            if (WAY_WIDTH'(i) == sel)
                age_new[i] = '0;
            else if (age_q[i][a_set] < age_q[sel][a_set])
                age_new[i] = age_q[i][a_set] + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int w = 0; w < WAYS; w++) begin
                for (int s = 0; s < SETS; s++) begin
                    valid_q[w][s] <= 1'b0;
                    dirty_q[w][s] <= 1'b0;
                    age_q[w][s]   <= WAY_WIDTH'(w);
                end
            end
        end else if (busy) begin
            for (int w = 0; w < WAYS; w++) begin
                valid_q[w][cnt] <= 1'b0;
                dirty_q[w][cnt] <= 1'b0;
                age_q[w][cnt]   <= WAY_WIDTH'(w);
            end
        end else begin
            if (do_inv) begin
                valid_q[match_way][a_set] <= 1'b0;
                dirty_q[match_way][a_set] <= 1'b0;
            end
            if (do_store) begin
                valid_q[sel][a_set] <= 1'b1;
                dirty_q[sel][a_set] <= 1'b0;
            end
            if (do_edit)
                dirty_q[sel][a_set] <= 1'b1;
            if (touch) begin
                for (int w = 0; w < WAYS; w++)
                    age_q[w][a_set] <= age_new[w];
            end
        end
    end

    // Tag and data storage carry no reset; valid bits qualify them.
    always_ff @(posedge clk) begin
        if (wr_data)
            data_q[sel][a_didx] <= din;
        if (do_store)
            tag_q[sel][a_set] <= a_tag;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            dout <= '0;
        else
            dout <= data_q[sel][a_didx];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            flush_done <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            flush_done <= flush_done_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        cnt_nxt        = cnt;
        flush_done_nxt = 1'b0;
        unique case (state)
            IDLE: begin
                if (flush) begin
                    state_nxt = SWEEP;
                    cnt_nxt   = '0;
                end
            end
            SWEEP: begin
                cnt_nxt = cnt + 1'b1;
                if (cnt == SET_INDEX_WIDTH'(SETS - 1)) begin
                    state_nxt      = IDLE;
                    cnt_nxt        = '0;
                    flush_done_nxt = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_cache_sa_array.sv
// Bench for cache_sa_array: table of request vectors with a
// dout scoreboard, plus hand sequences for flush and reset abort.
module tb_cache_sa_array;

    localparam logic [31:0] A = 32'h0000_0010;
    localparam logic [31:0] B = 32'h0000_0210;
    localparam logic [31:0] C = 32'h0000_0410;
    localparam logic [31:0] D = 32'h0000_0610;
    localparam logic [31:0] S20 = 32'h0000_0140;

    localparam logic [2:0] IDL = 3'd0;
    localparam logic [2:0] LD  = 3'd1;
    localparam logic [2:0] ST  = 3'd2;
    localparam logic [2:0] ED  = 3'd3;
    localparam logic [2:0] IV  = 3'd4;

    localparam int NV = 21;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] addr;
    logic [31:0] din;
    logic        load;
    logic        store;
    logic        edit;
    logic        invalid;
    logic        flush;
    logic        hit;
    logic        hit_way;
    logic        victim_way;
    logic        valid;
    logic        dirty;
    logic [22:0] tag;
    logic [31:0] dout;
    logic        busy;
    logic        flush_done;

    cache_sa_array dut (
        .clk        (clk),
        .rst        (rst),
        .addr       (addr),
        .din        (din),
        .load       (load),
        .store      (store),
        .edit       (edit),
        .invalid    (invalid),
        .flush      (flush),
        .hit        (hit),
        .hit_way    (hit_way),
        .victim_way (victim_way),
        .valid      (valid),
        .dirty      (dirty),
        .tag        (tag),
        .dout       (dout),
        .busy       (busy),
        .flush_done (flush_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] d;
        logic        h;
        logic        hw;
        logic        vic;
        logic        val;
        logic        dir;
        logic        ct;
        logic [22:0] tg;
        logic        cd;
        logic [31:0] dv;
    } vec_t;

    typedef struct {
        int          idx;
        logic [31:0] dv;
    } exp_t;

    vec_t vt [NV];
    exp_t sb [$];
    int   nvec = 0;
    int   nerr = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic idle_inputs();
        load    = 1'b0;
        store   = 1'b0;
        edit    = 1'b0;
        invalid = 1'b0;
        flush   = 1'b0;
    endtask

    task automatic run_vec(input int i);
        vec_t v;
        exp_t e;
        v       = vt[i];
        load    = (v.op == LD);
        store   = (v.op == ST);
        edit    = (v.op == ED);
        invalid = (v.op == IV);
        addr    = v.a;
        din     = v.d;
        @(negedge clk);
        chk($sformatf("v%0d.hit", i), 32'(hit), 32'(v.h));
        chk($sformatf("v%0d.hit_way", i), 32'(hit_way), 32'(v.hw));
        chk($sformatf("v%0d.victim", i), 32'(victim_way), 32'(v.vic));
        chk($sformatf("v%0d.valid", i), 32'(valid), 32'(v.val));
        chk($sformatf("v%0d.dirty", i), 32'(dirty), 32'(v.dir));
        if (v.ct)
            chk($sformatf("v%0d.tag", i), 32'(tag), 32'(v.tg));
        if (v.cd)
            sb.push_back('{i, v.dv});
        @(posedge clk);
        #1;
        idle_inputs();
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk($sformatf("v%0d.dout", e.idx), dout, e.dv);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int nb;
        int nd;
        // op addr din | hit hw vic val dir ct tag | cd dout
        vt[0]  = '{IDL, A, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0,
                   1'b0, 23'd0, 1'b0, 32'h0};
        vt[1]  = '{ST, A, 32'h11, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0,
                   1'b0, 23'd0, 1'b0, 32'h0};
        vt[2]  = '{ST, B, 32'h22, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                   1'b0, 23'd0, 1'b0, 32'h0};
        vt[3]  = '{LD, A, 32'h0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0,
                   1'b1, 23'd0, 1'b1, 32'h11};
        vt[4]  = '{LD, B, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0,
                   1'b1, 23'd1, 1'b1, 32'h22};
        vt[5]  = '{LD, A, 32'h0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0,
                   1'b1, 23'd0, 1'b1, 32'h11};
        vt[6]  = '{ST, C, 32'h33, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0,
                   1'b1, 23'd1, 1'b1, 32'h22};
        vt[7]  = '{LD, B, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0,
                   1'b1, 23'd0, 1'b1, 32'h11};
        vt[8]  = '{LD, C, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0,
                   1'b1, 23'd0, 1'b1, 32'h33};
        vt[9]  = '{LD, A, 32'h0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0,
                   1'b1, 23'd0, 1'b1, 32'h11};
        vt[10] = '{ED, A, 32'h44, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0,
                   1'b1, 23'd2, 1'b1, 32'h11};
        vt[11] = '{LD, C, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0,
                   1'b1, 23'd2, 1'b1, 32'h33};
        vt[12] = '{IDL, D, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1,
                   1'b1, 23'd0, 1'b1, 32'h44};
        vt[13] = '{ED, D, 32'h55, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1,
                   1'b1, 23'd0, 1'b1, 32'h44};
        vt[14] = '{IDL, D, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1,
                   1'b1, 23'd0, 1'b1, 32'h44};
        vt[15] = '{LD, A, 32'h0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1,
                   1'b1, 23'd0, 1'b1, 32'h44};
        vt[16] = '{IV, C, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0,
                   1'b1, 23'd2, 1'b1, 32'h33};
        vt[17] = '{IDL, C, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                   1'b1, 23'd2, 1'b1, 32'h33};
        vt[18] = '{ST, 32'h14, 32'h66, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0,
                   1'b1, 23'd2, 1'b0, 32'h0};
        vt[19] = '{LD, 32'h14, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0,
                   1'b1, 23'd2, 1'b1, 32'h66};
        vt[20] = '{LD, A, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0,
                   1'b1, 23'd2, 1'b1, 32'h44};

        rst  = 1'b1;
        addr = A;
        din  = '0;
        idle_inputs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst.hit", 32'(hit), 32'd0);
        chk("rst.valid", 32'(valid), 32'd0);
        chk("rst.victim", 32'(victim_way), 32'd1);
        chk("rst.dout", dout, 32'd0);
        chk("rst.busy", 32'(busy), 32'd0);
        chk("rst.done", 32'(flush_done), 32'd0);
        @(posedge clk);
        #1;

        for (int i = 0; i < NV; i++)
            run_vec(i);

        // Flush sweep: way 1 of set 1 holds A at this point.
        addr  = A;
        flush = 1'b1;
        @(negedge clk);
        chk("flush.hit_masked", 32'(hit), 32'd0);
        @(posedge clk);
        #1;
        flush = 1'b0;
        nb = 0;
        nd = 0;
        for (int k = 0; k < 64; k++) begin
            @(negedge clk);
            if (k == 0)
                chk("busy.hit_masked", 32'(hit), 32'd0);
            if (busy) nb++;
            if (flush_done) nd++;
            store = (k == 20);
            if (k == 20) begin
                addr = C;
                din  = 32'h77;
            end
            if (!busy) break;
        end
        chk("flush.busy_cycles", 32'(nb), 32'd32);
        chk("flush.done_pulses", 32'(nd), 32'd1);
        @(negedge clk);
        chk("flush.done_width", 32'(flush_done), 32'd0);
        addr = A;
        #1;
        chk("flush.A_miss", 32'(hit), 32'd0);
        addr = C;
        #1;
        chk("flush.C_miss", 32'(hit), 32'd0);
        for (int s = 0; s < 32; s++) begin
            @(negedge clk);
            addr = 32'(s) << 4;
            #1;
            chk($sformatf("flush.set%0d.victim", s),
                32'(victim_way), 32'd1);
            chk($sformatf("flush.set%0d.valid", s),
                32'(valid), 32'd0);
        end

        // Reset during a sweep, with a live line in set 20.
        @(posedge clk);
        #1;
        addr  = S20;
        din   = 32'h99;
        store = 1'b1;
        @(posedge clk);
        #1;
        store = 1'b0;
        @(negedge clk);
        chk("s20.hit", 32'(hit), 32'd1);
        @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        repeat (11) @(negedge clk);
        chk("abort.busy_before", 32'(busy), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("abort.busy", 32'(busy), 32'd0);
        chk("abort.victim", 32'(victim_way), 32'd1);
        chk("abort.valid", 32'(valid), 32'd0);
        chk("abort.hit", 32'(hit), 32'd0);
        chk("abort.dout", dout, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        nb = 0;
        nd = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (busy) nb++;
            if (flush_done) nd++;
        end
        chk("abort.busy_after", 32'(nb), 32'd0);
        chk("abort.no_done", 32'(nd), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 nvec, nerr);
        $finish;
    end

endmodule
